// File: rtl/aes_sbox.sv
// ============================================================================
// aes_sbox -- AES SubBytes / InvSubBytes byte substitution, registered.
//
// The substitution is computed arithmetically: multiplicative inverse in
// GF(2^8) (mod x^8+x^4+x^3+x+1, inv(0)=0) combined with the AES affine
// transform.  The inversion is done in the composite field GF((2^4)^2):
//   GF(2^4) = GF(2)[w]/(w^4+w+1)
//   GF(2^8) ~ GF(2^4)[Y]/(Y^2+Y+lambda)
// The change-of-basis matrices (isomorphism map and its inverse) are derived
// at elaboration time by constant functions: a root w of w^4+w+1 and a root
// Y of Y^2+Y+lambda are searched for inside the AES field, which fixes the
// basis {1,w,w^2,w^3, Y,wY,w^2Y,w^3Y}.  In hardware the maps collapse to
// fixed XOR networks; no lookup table is built.
//
// Parameters:
//   INVERSE  0 = forward S-box, 1 = inverse S-box (InvSubBytes)
//
// Compile-time option:
//   SBOX_PIPE_EN  when defined, adds a register stage at the GF(2^4)
//                 boundary (after iso map + square/scale/multiply, before
//                 the GF(2^4) inverse).  Latency becomes 2 cycles; my_x is
//                 delayed to match.  Undefined: 1-cycle latency.
//
// Ports:
//   clk   in   1  rising-edge clock
//   rst   in   1  asynchronous active-low reset, clears every register
//   x     in   8  byte to substitute, sampled every rising edge
//   y     out  8  registered S(x) (or InvS(x) when INVERSE=1)
//   my_x  out  8  registered copy of x, aligned with y
// ============================================================================
module aes_sbox #(
  parameter bit INVERSE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] x,
  output logic [7:0] y,
  output logic [7:0] my_x
);

  localparam logic [7:0] FWD_AFF_C = 8'h63;
  localparam logic [7:0] INV_AFF_C = 8'h05;

  // --------------------------------------------------------------------------
  // Field arithmetic helpers
  // --------------------------------------------------------------------------

  // GF(2^8) multiply, AES polynomial.  Only used at elaboration time.
  function automatic logic [7:0] gf8_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // GF(2^4) multiply mod w^4+w+1.
  function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] acc;
    logic [3:0] sh;
    acc = 4'h0;
    sh  = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'h3 : 4'h0);
    end
    return acc;
  endfunction

  // GF(2^4) squaring is linear: (a3 w^3 + a2 w^2 + a1 w + a0)^2 reduced
  // with w^4 = w+1, w^6 = w^3+w^2.
  function automatic logic [3:0] gf4_sq(input logic [3:0] a);
    return {a[3], a[3] ^ a[1], a[2], a[2] ^ a[0]};
  endfunction

  // a^-1 = a^14 = a^8 * a^4 * a^2; maps 0 to 0 as required.
  function automatic logic [3:0] gf4_inv(input logic [3:0] a);
    logic [3:0] a2;
    logic [3:0] a4;
    logic [3:0] a8;
    a2 = gf4_sq(a);
    a4 = gf4_sq(a2);
    a8 = gf4_sq(a4);
    return gf4_mul(gf4_mul(a8, a4), a2);
  endfunction

  // Root of w^4+w+1 inside GF(2^8) (embeds GF(2^4) as a subfield).
  function automatic logic [7:0] find_w();
    logic [7:0] r;
    logic [7:0] e8;
    logic [7:0] e2;
    r = 8'h00;
    for (int e = 2; e < 256; e++) begin
      e8 = e[7:0];
      e2 = gf8_mul(e8, e8);
      if (r == 8'h00 && (gf8_mul(e2, e2) ^ e8 ^ 8'h01) == 8'h00) r = e8;
    end
    return r;
  endfunction

  // Smallest lambda in GF(2^4) for which Y^2+Y+lambda has no root in
  // GF(2^4), i.e. the quadratic extension polynomial is irreducible.
  function automatic logic [3:0] find_lambda();
    logic [3:0] lam;
    logic [3:0] t4;
    logic       hit;
    lam = 4'h0;
    for (int l = 1; l < 16; l++) begin
      hit = 1'b0;
      for (int t = 0; t < 16; t++) begin
        t4 = t[3:0];
        if ((gf4_mul(t4, t4) ^ t4) == l[3:0]) hit = 1'b1;
      end
      if (!hit && lam == 4'h0) lam = l[3:0];
    end
    return lam;
  endfunction

  // Image of a GF(2^4) element (polynomial basis in w) inside GF(2^8).
  function automatic logic [7:0] embed(input logic [3:0] v, input logic [7:0] w);
    logic [7:0] acc;
    logic [7:0] pw;
    acc = 8'h00;
    pw  = 8'h01;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) acc = acc ^ pw;
      pw = gf8_mul(pw, w);
    end
    return acc;
  endfunction

  // Root Y of Y^2+Y+lambda inside GF(2^8).
  function automatic logic [7:0] find_y(input logic [3:0] lam, input logic [7:0] w);
    logic [7:0] ll;
    logic [7:0] r;
    logic [7:0] e8;
    logic       found;
    ll    = embed(lam, w);
    r     = 8'h00;
    found = 1'b0;
    for (int e = 0; e < 256; e++) begin
      e8 = e[7:0];
      if (!found && (gf8_mul(e8, e8) ^ e8 ^ ll) == 8'h00) begin
        r     = e8;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Composite element {h,l} = h*Y + l, expressed in the AES basis.
  function automatic logic [7:0] comp_to_std(input logic [7:0] c, input logic [7:0] w,
                                             input logic [7:0] yr);
    return gf8_mul(embed(c[7:4], w), yr) ^ embed(c[3:0], w);
  endfunction

  // Columns of the composite->AES matrix (column j = image of bit j).
  function automatic logic [63:0] build_map_cols(input logic [7:0] w, input logic [7:0] yr);
    logic [63:0] cols;
    cols = '0;
    for (int j = 0; j < 8; j++) begin
      cols[8*j +: 8] = comp_to_std(8'h01 << j, w, yr);
    end
    return cols;
  endfunction

  // Columns of the AES->composite matrix: for every unit vector e_j find the
  // composite element that maps onto it (the map is a bijection).
  function automatic logic [63:0] build_iso_cols(input logic [7:0] w, input logic [7:0] yr);
    logic [63:0] cols;
    logic [7:0]  c8;
    logic [7:0]  s;
    cols = '0;
    for (int c = 0; c < 256; c++) begin
      c8 = c[7:0];
      s  = comp_to_std(c8, w, yr);
      for (int j = 0; j < 8; j++) begin
        if (s == (8'h01 << j)) cols[8*j +: 8] = c8;
      end
    end
    return cols;
  endfunction

  // Apply a constant 8x8 GF(2) matrix given as columns: a pure XOR network.
  function automatic logic [7:0] lin_map(input logic [7:0] v, input logic [63:0] cols);
    logic [7:0] acc;
    acc = 8'h00;
    for (int j = 0; j < 8; j++) begin
      if (v[j]) acc = acc ^ cols[8*j +: 8];
    end
    return acc;
  endfunction

  localparam logic [7:0]  W_ROOT   = find_w();
  localparam logic [3:0]  LAMBDA   = find_lambda();
  localparam logic [7:0]  Y_ROOT   = find_y(LAMBDA, W_ROOT);
  localparam logic [63:0] ISO_COLS = build_iso_cols(W_ROOT, Y_ROOT);
  localparam logic [63:0] MAP_COLS = build_map_cols(W_ROOT, Y_ROOT);

  // Multiply by the constant lambda.
  function automatic logic [3:0] gf4_scale(input logic [3:0] a);
    return gf4_mul(a, LAMBDA);
  endfunction

  // --------------------------------------------------------------------------
  // Stage A: optional inverse affine, isomorphism map, then
  //   (hY + l)^-1 = (h*Y + (h+l)) * d^-1,  d = lambda*h^2 + l*(h+l)
  // --------------------------------------------------------------------------
  logic [7:0] pre_a;
  logic [7:0] q_a;
  logic [3:0] h_a;
  logic [3:0] l_a;
  logic [3:0] hl_a;
  logic [3:0] d_a;

  assign q_a  = lin_map(pre_a, ISO_COLS);
  assign h_a  = q_a[7:4];
  assign l_a  = q_a[3:0];
  assign hl_a = h_a ^ l_a;
  assign d_a  = gf4_scale(gf4_sq(h_a)) ^ gf4_mul(l_a, hl_a);

  // --------------------------------------------------------------------------
  // Optional register at the GF(2^4) boundary
  // --------------------------------------------------------------------------
  logic [3:0] h_b;
  logic [3:0] hl_b;
  logic [3:0] d_b;
  logic [7:0] x_b;

`ifdef SBOX_PIPE_EN
  logic [3:0] h_reg;
  logic [3:0] hl_reg;
  logic [3:0] d_reg;
  logic [7:0] x_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_reg  <= 4'h0;
      hl_reg <= 4'h0;
      d_reg  <= 4'h0;
      x_reg  <= 8'h00;
    end else begin
      h_reg  <= h_a;
      hl_reg <= hl_a;
      d_reg  <= d_a;
      x_reg  <= x;
    end
  end

  assign h_b  = h_reg;
  assign hl_b = hl_reg;
  assign d_b  = d_reg;
  assign x_b  = x_reg;
`else
  assign h_b  = h_a;
  assign hl_b = hl_a;
  assign d_b  = d_a;
  assign x_b  = x;
`endif

  // --------------------------------------------------------------------------
  // Stage B: GF(2^4) inverse, the two products, inverse map
  // --------------------------------------------------------------------------
  logic [3:0] di_b;
  logic [7:0] inv_b;
  logic [7:0] y_next;

  assign di_b  = gf4_inv(d_b);
  assign inv_b = lin_map({gf4_mul(h_b, di_b), gf4_mul(hl_b, di_b)}, MAP_COLS);

  // Affine step: before the inversion for InvS, after it for S.
  genvar gi;
  generate
    if (INVERSE) begin : g_inv
      for (gi = 0; gi < 8; gi++) begin : g_aff
        assign pre_a[gi] = x[(gi + 2) % 8] ^ x[(gi + 5) % 8] ^ x[(gi + 7) % 8]
                         ^ INV_AFF_C[gi];
      end
      assign y_next = inv_b;
    end else begin : g_fwd
      assign pre_a = x;
      for (gi = 0; gi < 8; gi++) begin : g_aff
        assign y_next[gi] = inv_b[gi] ^ inv_b[(gi + 4) % 8] ^ inv_b[(gi + 5) % 8]
                          ^ inv_b[(gi + 6) % 8] ^ inv_b[(gi + 7) % 8] ^ FWD_AFF_C[gi];
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Output registers: y and my_x come straight from flops
  // --------------------------------------------------------------------------
  logic [7:0] y_reg;
  logic [7:0] my_x_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_reg    <= 8'h00;
      my_x_reg <= 8'h00;
    end else begin
      y_reg    <= y_next;
      my_x_reg <= x_b;
    end
  end

  assign y    = y_reg;
  assign my_x = my_x_reg;

endmodule

// File: tb/tb_aes_sbox.sv
// Directed/sweep bench for aes_sbox: forward instance, stand-alone inverse
// instance, and an inverse instance chained behind the forward one.
module tb_aes_sbox;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] x_f, y_f, my_x_f;
  logic [7:0] x_i, y_i, my_x_i;
  logic [7:0] y_r, my_x_r;

  always #5 clk = ~clk;

`ifdef SBOX_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  aes_sbox #(.INVERSE(1'b0)) u_fwd (.clk(clk), .rst(rst), .x(x_f), .y(y_f), .my_x(my_x_f));
  aes_sbox #(.INVERSE(1'b1)) u_inv (.clk(clk), .rst(rst), .x(x_i), .y(y_i), .my_x(my_x_i));
  aes_sbox #(.INVERSE(1'b1)) u_rt  (.clk(clk), .rst(rst), .x(y_f), .y(y_r), .my_x(my_x_r));

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [7:0] FWD_X [0:4] = '{8'h00, 8'h01, 8'h53, 8'h10, 8'hFF};
  localparam logic [7:0] FWD_Y [0:4] = '{8'h63, 8'h7C, 8'hED, 8'hCA, 8'h16};
  localparam logic [7:0] INV_X [0:3] = '{8'h63, 8'hED, 8'h16, 8'h7C};
  localparam logic [7:0] INV_Y [0:3] = '{8'h00, 8'h53, 8'hFF, 8'h01};

  logic [7:0] inv_tab [0:255];

  int n_vec    = 0;
  int n_miscmp = 0;

  task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] want);
    n_vec++;
    if (obs !== want) begin
      n_miscmp++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, want);
    end else begin
      $display("ok   %s: %02h", tag, obs);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] e8;
    logic [7:0] x_new;

    for (int i = 0; i < 256; i++) inv_tab[SBOX[i]] = 8'(i);

    rst = 1'b1;
    x_f = 8'h00;
    x_i = 8'h00;

    // Power-up reset, asserted between edges.
    #2 rst = 1'b0;
    #1;
    check_byte("por_y", y_f, 8'h00);
    check_byte("por_my_x", my_x_f, 8'h00);
    check_byte("por_rt_y", y_r, 8'h00);
    repeat (2) tick();
    #2 rst = 1'b1;

    // Get a non-zero output, then reset asynchronously with x=A5.
    x_f = 8'h01;
    repeat (LAT) tick();
    check_byte("pre_rst_y", y_f, 8'h7C);
    #2;
    x_f = 8'hA5;
    rst = 1'b0;
    #1;
    check_byte("rst_async_y", y_f, 8'h00);
    check_byte("rst_async_my_x", my_x_f, 8'h00);
    repeat (2) tick();
    check_byte("rst_hold_y", y_f, 8'h00);
    check_byte("rst_hold_my_x", my_x_f, 8'h00);
    #2 rst = 1'b1;
    repeat (LAT) tick();
    check_byte("rst_rel_my_x", my_x_f, 8'hA5);
    check_byte("rst_rel_y", y_f, 8'h06);

    // Directed forward and inverse vectors.
    for (int i = 0; i < 5; i++) begin
      x_f = FWD_X[i];
      if (i < 4) x_i = INV_X[i];
      repeat (LAT) tick();
      check_byte($sformatf("fwd_%02h_y", FWD_X[i]), y_f, FWD_Y[i]);
      check_byte($sformatf("fwd_%02h_my_x", FWD_X[i]), my_x_f, FWD_X[i]);
      if (i < 4) begin
        check_byte($sformatf("inv_%02h_y", INV_X[i]), y_i, INV_Y[i]);
        check_byte($sformatf("inv_%02h_my_x", INV_X[i]), my_x_i, INV_X[i]);
      end
    end

    // Exhaustive sweep, counter wraps past FF naturally; the chained inverse
    // instance trails by LAT more cycles.
    x_f = 8'h00;
    x_i = 8'h00;
    for (int c = 1; c <= 255 + 2 * LAT; c++) begin
      tick();
      x_f = x_f + 8'h01;
      x_i = x_i + 8'h01;
      if (c >= LAT && c - LAT <= 255) begin
        e8 = 8'(c - LAT);
        check_byte($sformatf("sw_f_mx_%02h", e8), my_x_f, e8);
        check_byte($sformatf("sw_f_y_%02h", e8), y_f, SBOX[e8]);
        check_byte($sformatf("sw_i_mx_%02h", e8), my_x_i, e8);
        check_byte($sformatf("sw_i_y_%02h", e8), y_i, inv_tab[e8]);
        if (c - LAT == 255) check_byte("sweep_ff_y", y_f, 8'h16);
      end
      if (c >= 2 * LAT) begin
        e8 = 8'(c - 2 * LAT);
        check_byte($sformatf("rt_mx_%02h", e8), my_x_r, SBOX[e8]);
        check_byte($sformatf("rt_y_%02h", e8), y_r, e8);
      end
    end

    // Mid-stream reset pulse shorter than a clock period.
    x_f = 8'h40;
    for (int k = 0; k < 3; k++) begin
      tick();
      x_f = x_f + 8'h01;
    end
    #2 rst = 1'b0;
    #1;
    check_byte("mid_rst_y", y_f, 8'h00);
    check_byte("mid_rst_my_x", my_x_f, 8'h00);
    check_byte("mid_rst_rt_y", y_r, 8'h00);
    check_byte("mid_rst_rt_my_x", my_x_r, 8'h00);
    #2 rst = 1'b1;
    x_new = x_f;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      if (k < LAT) begin
        check_byte("mid_fill_y", y_f, 8'h00);
        check_byte("mid_fill_my_x", my_x_f, 8'h00);
      end else begin
        check_byte("mid_new_my_x", my_x_f, x_new);
        check_byte("mid_new_y", y_f, SBOX[x_new]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
